// File: rtl/rca_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package rca_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ripple_carry.sv
// 4-bit ripple-carry adder, purely combinational: {carry, sum} = x + y + z.
module ripple_carry (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       z,
  output logic [3:0] sum,
  output logic       carry
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = z;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    carry = c[4];
  end

endmodule

// File: rtl/rca_seq_ctrl.sv
// WIDTH-bit adder built by sequencing one 4-bit ripple_carry, LSB nibble first; done pulses NIBS cycles after accept.
// Optional subtract mode (sub port, a - b) when RCA_SUB_EN is defined.
module rca_seq_ctrl
  import rca_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef RCA_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int NIBS  = WIDTH / NIB_W;
  localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;

  if (WIDTH % NIB_W != 0) begin : g_width_chk
    $error("rca_seq_ctrl: WIDTH must be a multiple of 4");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;

  logic [NIB_W-1:0]   nib_x, nib_y, nib_sum;
  logic               nib_carry;
  logic [WIDTH-1:0]   b_cap;
  logic               c_cap;

  assign nib_x = a_q[int'(idx_q)*NIB_W +: NIB_W];
  assign nib_y = b_q[int'(idx_q)*NIB_W +: NIB_W];

  ripple_carry u_rca (
    .x     (nib_x),
    .y     (nib_y),
    .z     (carry_q),
    .sum   (nib_sum),
    .carry (nib_carry)
  );

  // Subtraction is a + ~b + 1, so only the captured operand and seed carry differ.
`ifdef RCA_SUB_EN
  assign b_cap = sub ? ~b : b;
  assign c_cap = sub ? 1'b1 : cin;
`else
  assign b_cap = b;
  assign c_cap = cin;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = RUN;
          a_d      = a;
          b_d      = b_cap;
          carry_d  = c_cap;
          idx_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        result_d[int'(idx_q)*NIB_W +: NIB_W] = nib_sum;
        carry_d = nib_carry;
        if (idx_q == IDX_W'(NIBS - 1)) begin
          cout_d  = nib_carry;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Self-checking bench for rca_seq_ctrl (WIDTH=16) against an arithmetic reference model.
module tb_rca_seq_ctrl;

  localparam int WIDTH = 16;
  localparam int NIBS  = 4;

  logic             clk = 1'b0;
  logic             rst, start, cin;
  logic [WIDTH-1:0] a, b;
`ifdef RCA_SUB_EN
  logic             sub;
`endif
  logic             busy, done, cout;
  logic [WIDTH-1:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rca_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .cin    (cin),
`ifdef RCA_SUB_EN
    .sub    (sub),
`endif
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, bit 16 is the carry-out.
  function automatic logic [16:0] ref_op(input logic [15:0] x, input logic [15:0] y,
                                         input logic c, input logic s);
    if (s) return {1'b0, x} + {1'b0, ~y} + 17'd1;
    return {1'b0, x} + {1'b0, y} + {16'd0, c};
  endfunction

  task automatic set_sub(input logic s);
`ifdef RCA_SUB_EN
    sub = s;
`endif
  endtask

  // One complete operation; optionally pokes start with other operands mid-run.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb2,
                        input logic tc, input logic ts, input bit poke);
    logic [16:0] exp;
    int cyc;
    bit seen;
    exp = ref_op(ta, tb2, tc, ts);
    @(negedge clk);
    a = ta; b = tb2; cin = tc; set_sub(ts); start = 1'b1;
    cyc = 0; seen = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (poke && cyc == 2) begin
        start = 1'b1; a = ~ta; b = ta ^ 16'h1234; cin = ~tc; set_sub(~ts);
      end
      if (done) seen = 1;
      else chk({tag, " busy"}, {31'd0, busy}, 32'd1);
    end
    start = 1'b0;
    chk({tag, " latency"}, cyc - 1, NIBS);
    chk({tag, " result"}, {16'd0, result}, {16'd0, exp[15:0]});
    chk({tag, " cout"}, {31'd0, cout}, {31'd0, exp[16]});
    @(negedge clk);
    chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, " idle"}, {31'd0, busy}, 32'd0);
    chk({tag, " held"}, {16'd0, result}, {16'd0, exp[15:0]});
  endtask

  initial begin
    logic [16:0] exp;
    logic [15:0] ra, rb;
    logic        rc, rs;
    int cyc, prev, k, ndone;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; set_sub(1'b0);
    repeat (2) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", {16'd0, result}, 32'd0);
    chk("reset cout", {31'd0, cout}, 32'd0);
    rst = 1'b0;

    run_op("t1_5555", 16'h5555, 16'h5555, 1'b0, 1'b0, 0);
    run_op("t2_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op("t3_cin", 16'h0000, 16'hFFFF, 1'b1, 1'b0, 0);
    run_op("t4_poke", 16'h1234, 16'h4321, 1'b0, 1'b0, 1);

    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
`ifdef RCA_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op("rand", ra, rb, rc, rs, ($urandom_range(0, 3) == 0));
    end

    // Start held high: back-to-back ops, operands refreshed as each completes.
    @(negedge clk);
    ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
    a = ra; b = rb; cin = rc; set_sub(1'b0); start = 1'b1;
    exp = ref_op(ra, rb, rc, 1'b0);
    cyc = 0; prev = 0; k = 0;
    while (k < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        chk("held result", {16'd0, result}, {16'd0, exp[15:0]});
        chk("held cout", {31'd0, cout}, {31'd0, exp[16]});
        if (k > 0) chk("held interval", cyc - prev, NIBS + 1);
        prev = cyc;
        k++;
        ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
        a = ra; b = rb; cin = rc;
        exp = ref_op(ra, rb, rc, 1'b0);
        if (k == 4) start = 1'b0;
      end
    end
    start = 1'b0;
    chk("held count", k, 4);
    repeat (2) @(negedge clk);

    // Reset during the second RUN cycle, with start also high: rst wins.
    a = 16'hABCD; b = 16'h1111; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst result", {16'd0, result}, 32'd0);
    chk("rst cout", {31'd0, cout}, 32'd0);
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("rst no_done", ndone, 0);
    run_op("after_rst", 16'h8000, 16'h8000, 1'b1, 1'b0, 0);

`ifdef RCA_SUB_EN
    run_op("sub_5_3", 16'h0005, 16'h0003, 1'b0, 1'b1, 0);
    run_op("sub_3_5", 16'h0003, 16'h0005, 1'b1, 1'b1, 0);
    run_op("sub0_add", 16'h0003, 16'h0005, 1'b1, 1'b0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
